// File: rtl/tdm_demux8_if.sv
// Bus bundle for the TDM demultiplexer: serial beat in, assembled frame and status out.
interface tdm_demux8_if;
    logic       D;
    logic       V;
    logic       F;
    logic [7:0] O;
    logic       OV;
    logic [2:0] S;
    logic       LOCK;
    logic       ERR;

    modport master (output D, V, F, input O, OV, S, LOCK, ERR);
    modport slave  (input D, V, F, output O, OV, S, LOCK, ERR);
endinterface

// File: rtl/tdm_demux8.sv
// 1:8 TDM demultiplexer: serial slot bits are assembled into an 8-bit frame,
// with frame-marker alignment and short-frame detection.
module tdm_demux8 #(
    parameter bit SYNC_REQ = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux8_if.slave    bus
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;
    localparam state_t RST_STATE = SYNC_REQ ? UNLOCKED : LOCKED;

    state_t     state_q, state_d;
    logic [7:0] b_q, b_d;
    logic [2:0] s_q, s_d;
    logic [7:0] o_q, o_d;
    logic       ov_q, ov_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            b_q     <= 8'h00;
            s_q     <= 3'd0;
            o_q     <= 8'h00;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            o_q     <= o_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        o_d     = o_q;
        ov_d    = 1'b0;
        err_d   = 1'b0;
        if (bus.V) begin
            if (bus.F) begin
                // A marker always realigns; it is only an error if it cuts a frame short.
                err_d   = (state_q == LOCKED) && (s_q != 3'd0);
                b_d[0]  = bus.D;
                s_d     = 3'd1;
                state_d = LOCKED;
            end else if (state_q == LOCKED) begin
                b_d[s_q] = bus.D;
                s_d      = s_q + 3'd1;
                if (s_q == 3'd7) begin
                    o_d  = {bus.D, b_q[6:0]};
                    ov_d = 1'b1;
                end
            end
        end
    end

    assign bus.O    = o_q;
    assign bus.OV   = ov_q;
    assign bus.S    = s_q;
    assign bus.LOCK = (state_q == LOCKED);
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8: a frame-level model queues expected frames
// and error pulses; a negedge monitor checks every DUT output against it.
module tb_tdm_demux8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux8_if bus ();
    tdm_demux8_if bus0 ();

    tdm_demux8 #(.SYNC_REQ(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    tdm_demux8 #(.SYNC_REQ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus0.D = bus.D;
    assign bus0.V = bus.V;
    assign bus0.F = bus.F;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the frame in progress, lock flag, pending outputs.
    bit         m_lock = 1'b0;
    bit         m_bits[$];
    logic [7:0] exp_q[$];
    int         err_pend = 0;
    logic [7:0] last_o = 8'h00;
    bit         run = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_bits.delete();
        exp_q.delete();
        err_pend = 0;
        last_o = 8'h00;
    endtask

    task automatic model_step(input bit v, input bit f, input bit d);
        logic [7:0] frame;
        if (!v) return;
        if (f) begin
            if (m_lock && m_bits.size() != 0) err_pend++;
            m_bits.delete();
            m_bits.push_back(d);
            m_lock = 1'b1;
        end else if (m_lock) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                for (int k = 0; k < 8; k++) frame[k] = m_bits[k];
                exp_q.push_back(frame);
                m_bits.delete();
            end
        end
    endtask

    task automatic beat(input bit v, input bit f, input bit d);
        @(negedge clk);
        bus.V = v; bus.F = f; bus.D = d;
        @(posedge clk);
        model_step(v, f, d);
    endtask

    task automatic send_frame(input logic [7:0] val, input bit mark);
        for (int k = 0; k < 8; k++) beat(1'b1, mark && (k == 0), val[k]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: exact one-clock latency is enforced by requiring every queued
    // frame to be presented at the very next sample point.
    always @(negedge clk) begin
        if (run && rst_n) begin
            if (bus.OV) begin
                if (exp_q.size() == 0) chk("ov_unexpected", 8'd1, 8'd0);
                else begin
                    last_o = exp_q.pop_front();
                    chk("frame_O", bus.O, last_o);
                end
            end else if (exp_q.size() != 0) begin
                chk("ov_missing", 8'd0, 8'd1);
                void'(exp_q.pop_front());
            end
            chk("O_hold", bus.O, last_o);
            chk("ERR", {7'd0, bus.ERR}, {7'd0, err_pend != 0});
            err_pend = 0;
            chk("OV_ERR_excl", {7'd0, bus.OV & bus.ERR}, 8'd0);
            chk("S", {5'd0, bus.S}, 8'(m_bits.size()));
            chk("LOCK", {7'd0, bus.LOCK}, {7'd0, m_lock});
        end
    end

    initial begin
        bus.V = 1'b0; bus.F = 1'b0; bus.D = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_O", bus.O, 8'h00);
        chk("rst_S", {5'd0, bus.S}, 8'd0);
        chk("rst_LOCK", {7'd0, bus.LOCK}, 8'd0);
        chk("rst_OV_ERR", {6'd0, bus.OV, bus.ERR}, 8'd0);
        chk("rst0_LOCK", {7'd0, bus0.LOCK}, 8'd1);
        chk("rst0_S", {5'd0, bus0.S}, 8'd0);
        rst_n = 1'b1;
        run = 1'b1;

        // Unlocked filtering
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
        idle(1);
        chk("unlock_LOCK", {7'd0, bus.LOCK}, 8'd0);
        chk("unlock_O", bus.O, 8'h00);

        // Single frame, then one-hot walk with marker-free continuation
        send_frame(8'h01, 1'b1);
        idle(2);
        send_frame(8'h01, 1'b1);
        for (int k = 1; k < 8; k++) send_frame(8'(1 << k), 1'b0);
        idle(1);
        chk("walk_O", bus.O, 8'h80);

        // Valid gaps inside an A5 frame
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, k == 0, k inside {0, 2, 5, 7});
            if (k == 2 || k == 5) beat(1'b0, 1'b1, 1'b1);
        end
        idle(1);
        chk("gap_O", bus.O, 8'hA5);

        // Short frame, then a complete 3C frame
        beat(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(1);
        chk("short_O", bus.O, 8'h3C);

        // Asynchronous reset mid-frame
        send_frame(8'h5A, 1'b1);
        beat(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_O", bus.O, 8'h00);
        chk("midrst_S", {5'd0, bus.S}, 8'd0);
        chk("midrst_LOCK", {7'd0, bus.LOCK}, 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hFF, 1'b1);
        idle(1);
        chk("postrst_O", bus.O, 8'hFF);

        // Randomized traffic, including markers on idle beats
        for (int i = 0; i < 800; i++)
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter SYNC_REQ, default 1, meaning: 1 = serial bits are ignored until the first frame marker after reset; 0 = the block starts locked at slot 0 out of reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 D  input  1  serial time-multiplexed data bit (one slot per valid beat).
REQ-005 V  input  1  beat valid; D and F are sampled only when V=1.
REQ-006 F  input  1  frame marker; qualifies the D beat as slot 0.
REQ-007 O  output  8  registered demultiplexed frame; O[k] = bit received in slot k.
REQ-008 OV  output  1  one-cycle pulse: O updated with a complete frame.
REQ-009 S  output  3  registered slot index the next valid beat will be written to.
REQ-010 LOCK  output  1  high once frame alignment is established.
REQ-011 ERR  output  1  one-cycle pulse: frame marker arrived mid-frame (short frame).

Function
REQ-012 The block SHALL be the receive/distribute counterpart of the 8:1 select mux: the bit in slot k SHALL be routed to O[k]; select S SHALL be generated internally by the slot counter, not supplied externally.
REQ-013 The block SHALL hold an internal 8-bit assembly buffer B; B SHALL never drive O directly.
REQ-014 When V=0, B, S, O, and LOCK SHALL hold; F and D SHALL be ignored; OV and ERR SHALL be 0 on the next cycle.
REQ-015 When V=1 and F=1, the block SHALL write B[0]<=D, set S<=1, and set LOCK<=1, regardless of the current S or LOCK.
REQ-016 When V=1, F=1, LOCK=1, and S!=0, the block SHALL pulse ERR for one cycle and discard the partial frame; no OV SHALL be issued for it.
REQ-017 When V=1, F=0, and LOCK=1, the block SHALL write B[S]<=D and set S<=S+1 modulo 8.
REQ-018 When REQ-017 applies with S=7, O SHALL load {D, B[6:0]} and OV SHALL be 1 in the following cycle, with the same edge loading O and OV; S SHALL wrap to 0.
REQ-019 A marker-free continuation (F=0 at slot 0 after wrap) SHALL be accepted as the next frame; an F at slot 0 SHALL NOT raise ERR.
REQ-020 When V=1, F=0, and LOCK=0, the beat SHALL be discarded; S SHALL stay 0.
REQ-021 With SYNC_REQ=0, LOCK SHALL be 1 immediately after reset release, and S SHALL be 0.
REQ-022 Latency from the slot-7 beat to OV/O visibility SHALL be exactly one clock; back-to-back frames SHALL produce OV every 8 valid beats with no bubble.
REQ-023 O SHALL hold its value between OV pulses; OV and ERR SHALL never be high in the same cycle.
REQ-024 The state machine SHALL have the states UNLOCKED (LOCK=0) and LOCKED (LOCK=1).
REQ-025 The transition UNLOCKED->LOCKED SHALL occur on V&F.
REQ-026 There SHALL be no exit from LOCKED other than reset.

Reset
REQ-027 With rst_n=0, the block SHALL immediately force O=8'h00, OV=0, ERR=0, S=3'b000, B=8'h00, and LOCK=SYNC_REQ?0:1, independent of clk.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no OV or ERR SHALL be produced for it after release.
REQ-029 Reset release SHALL be synchronous-safe: the first edge after release SHALL act on inputs normally.

Verification
REQ-030 Unlock filtering, SYNC_REQ=1: after reset, 5 beats with V=1, F=0, D=1 -> LOCK=0, S=0, O=8'h00, and no OV.
REQ-031 Single frame: F on the first beat, then slot bits D = 1,0,0,0,0,0,0,0 (slot 0 first), all V=1 -> OV pulses once, exactly 1 clock after the 8th beat, and O=8'h01.
REQ-032 One-hot walk, matching the mux bench: 8 consecutive frames, frame k with only slot k = 1 -> O = 8'h01, 8'h02, 8'h04, ... 8'h80, with OV every 8 beats and no gaps.
REQ-033 V gaps: the 8'hA5 frame with V=0 inserted after slots 2 and 5 -> O=8'hA5, and OV follows the last valid beat by 1 clock.
REQ-034 Short frame: F, then 3 beats, then F again -> ERR is a 1-cycle pulse, with no OV for that frame, and S=1 after the second F; the completed following frame of 8'h3C yields O=8'h3C.
REQ-035 Reset mid-frame: drive rst_n low after 4 slots -> O=8'h00, S=0, and LOCK=0 immediately; after release and a clean frame of 8'hFF -> O=8'hFF.
